// File: rtl/write_back_v2_if.sv
// Write-back stage bundle: request, v0, result-beat handshake, register-file
// read/write ports and status. The stage uses the slave modport.
interface write_back_v2_if #(
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 8,
    parameter int VL_W     = $clog2(VLEN*MAX_LMUL/8) + 1
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_vd;
    logic [1:0]      req_lmul;
    logic [1:0]      req_sew;
    logic [VL_W-1:0] req_vl;
    logic [VL_W-1:0] req_vstart;
    logic            req_vm;
    logic            req_vma;
    logic            req_vta;
    logic [VLEN-1:0] v0;

    logic            res_valid;
    logic            res_ready;
    logic [VLEN-1:0] res_data;

    logic            rf_rd_en;
    logic [4:0]      rf_rd_addr;
    logic [VLEN-1:0] rf_rd_data;

    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [VLEN-1:0] rf_wr_data;

    logic            busy;
    logic            done;

    modport slave (
        input  req_valid, req_vd, req_lmul, req_sew, req_vl, req_vstart,
               req_vm, req_vma, req_vta, v0, res_valid, res_data, rf_rd_data,
        output req_ready, res_ready, rf_rd_en, rf_rd_addr,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, done
    );

    modport master (
        output req_valid, req_vd, req_lmul, req_sew, req_vl, req_vstart,
               req_vm, req_vma, req_vta, v0, res_valid, res_data, rf_rd_data,
        input  req_ready, res_ready, rf_rd_en, rf_rd_addr,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, done
    );
endinterface

// File: rtl/write_back_v2.sv
// Sequential vector write-back: walks the destination group one register per beat,
// merging result and old value under vstart/vl/v0. Macro WRITE_BACK_AGNOSTIC_ONES_EN writes agnostic elements as all-ones.
module write_back_v2 #(
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 8,
    parameter int VL_W     = $clog2(VLEN*MAX_LMUL/8) + 1
) (
    input logic            clock,
    input logic            reset,
    write_back_v2_if.slave wb
);
    localparam int LANES    = VLEN / 8;
    localparam int LANE_LOG = $clog2(LANES);
    localparam int LMUL_LOG = $clog2(MAX_LMUL);
    localparam int B_W      = (LMUL_LOG > 0) ? LMUL_LOG : 1;
    localparam int V0_IW    = $clog2(VLEN);

`ifdef WRITE_BACK_AGNOSTIC_ONES_EN
    localparam bit AGNOSTIC_ONES = 1'b1;
`else
    localparam bit AGNOSTIC_ONES = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, OLD, MERGE} state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [B_W-1:0]  beat_reg;
    logic [B_W-1:0]  last_reg;
    logic [4:0]      vd_reg;
    logic [1:0]      sew_reg;
    logic [VL_W-1:0] vl_reg;
    logic [VL_W-1:0] vstart_reg;
    logic            vm_reg;
    logic            vma_reg;
    logic            vta_reg;
    logic [VLEN-1:0] v0_reg;
    logic [VLEN-1:0] old_reg;

    logic            wr_en_reg;
    logic [4:0]      wr_addr_reg;
    logic [VLEN-1:0] wr_data_reg;
    logic            done_reg;

    logic            accept;
    logic            handshake;
    logic            is_last;
    logic [1:0]      lmul_eff;
    logic [B_W-1:0]  req_last;
    logic [4:0]      beat_addr;
    logic [3:0]      shamt;
    logic [VLEN-1:0] old_src;
    logic [VLEN-1:0] merged;

    assign is_last   = (beat_reg == last_reg);
    assign beat_addr = vd_reg + 5'(beat_reg);

    // Group size clamps to MAX_LMUL; last beat index is 2^lmul - 1.
    always_comb begin
        lmul_eff = wb.req_lmul;
        if (wb.req_lmul > 2'(LMUL_LOG)) begin
            lmul_eff = 2'(LMUL_LOG);
        end
        req_last = B_W'((32'd1 << lmul_eff) - 32'd1);
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wb.req_valid) begin
                    accept     = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                state_next = OLD;
            end
            OLD: begin
                if (wb.res_valid) begin
                    handshake  = 1'b1;
                    state_next = is_last ? IDLE : RD;
                end else begin
                    state_next = MERGE;
                end
            end
            MERGE: begin
                if (wb.res_valid) begin
                    handshake  = 1'b1;
                    state_next = is_last ? IDLE : RD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend on state (and reset) only; nothing combinational from res_valid.
    assign wb.req_ready  = (state_reg == IDLE) && !reset;
    assign wb.busy       = (state_reg != IDLE) && !reset;
    assign wb.res_ready  = ((state_reg == OLD) || (state_reg == MERGE)) && !reset;
    assign wb.rf_rd_en   = (state_reg == RD) && !reset;
    assign wb.rf_rd_addr = beat_addr;
    assign wb.rf_wr_en   = wr_en_reg;
    assign wb.rf_wr_addr = wr_addr_reg;
    assign wb.rf_wr_data = wr_data_reg;
    assign wb.done       = done_reg;

    // In OLD the read data is still on the port, so a handshake there merges it directly.
    assign old_src = (state_reg == OLD) ? wb.rf_rd_data : old_reg;

    // Element index of byte lane k in this beat: beat*(VLEN/SEW) + k/(SEW/8).
    assign shamt = 4'(LANE_LOG) - {2'b00, sew_reg};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [VL_W-1:0]  g_idx;
            logic [V0_IW-1:0] v0_idx;
            logic             prestart;
            logic             tail;
            logic             masked_off;
            logic [7:0]       old_b;
            logic [7:0]       res_b;
            logic [7:0]       agn_b;
            logic [7:0]       lane_b;

            always_comb begin
                g_idx      = (VL_W'(beat_reg) << shamt) + (VL_W'(gi) >> sew_reg);
                v0_idx     = V0_IW'(g_idx);
                prestart   = (g_idx < vstart_reg);
                tail       = (g_idx >= vl_reg);
                masked_off = !vm_reg && !v0_reg[v0_idx];
                old_b      = old_src[gi*8 +: 8];
                res_b      = wb.res_data[gi*8 +: 8];
                agn_b      = AGNOSTIC_ONES ? 8'hFF : old_b;
                lane_b     = res_b;
                if (prestart) begin
                    lane_b = old_b;
                end else if (tail) begin
                    lane_b = vta_reg ? agn_b : old_b;
                end else if (masked_off) begin
                    lane_b = vma_reg ? agn_b : old_b;
                end
            end

            assign merged[gi*8 +: 8] = lane_b;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            beat_reg    <= '0;
            last_reg    <= '0;
            vd_reg      <= '0;
            sew_reg     <= '0;
            vl_reg      <= '0;
            vstart_reg  <= '0;
            vm_reg      <= 1'b0;
            vma_reg     <= 1'b0;
            vta_reg     <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= handshake;
            done_reg  <= handshake && is_last;
            if (handshake) begin
                wr_addr_reg <= beat_addr;
                wr_data_reg <= merged;
                beat_reg    <= is_last ? '0 : beat_reg + B_W'(1);
            end
            if (accept) begin
                beat_reg   <= '0;
                last_reg   <= req_last;
                vd_reg     <= wb.req_vd;
                sew_reg    <= wb.req_sew;
                vl_reg     <= wb.req_vl;
                vstart_reg <= wb.req_vstart;
                vm_reg     <= wb.req_vm;
                vma_reg    <= wb.req_vma;
                vta_reg    <= wb.req_vta;
            end
        end
    end

    // Wide datapath registers need no reset: they are always loaded before use.
    always_ff @(posedge clock) begin
        if (accept) begin
            v0_reg <= wb.v0;
        end
        if (state_reg == OLD) begin
            old_reg <= wb.rf_rd_data;
        end
    end
endmodule
